// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI4-Lite channel bundle. Modports are named after the device on the far side:
// MASTER is the arbiter port facing a master, SLAVE is the arbiter port facing the slave.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport MASTER (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport SLAVE (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// N:1 AXI4-Lite arbiter with independent write and read owners; each grant is held
// from address phase through response so responses always return to the issuer.
module axi_lite_rr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = 0,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_lite_if.MASTER        m_if [NUM_MASTERS],
    axi_lite_if.SLAVE         s_if,
    output logic [GW-1:0]     wr_grant,
    output logic [GW-1:0]     rd_grant,
    output logic              wr_busy,
    output logic              rd_busy
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    logic [NUM_MASTERS-1:0] w_awvalid;
    logic [NUM_MASTERS-1:0] w_wvalid;
    logic [NUM_MASTERS-1:0] w_bready;
    logic [NUM_MASTERS-1:0] w_arvalid;
    logic [NUM_MASTERS-1:0] w_rready;
    logic [ADDR_WIDTH-1:0]  w_awaddr [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]  w_araddr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  w_wdata  [NUM_MASTERS];
    logic [SW-1:0]          w_wstrb  [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] w_awready;
    logic [NUM_MASTERS-1:0] w_wready;
    logic [NUM_MASTERS-1:0] w_bvalid;
    logic [NUM_MASTERS-1:0] w_arready;
    logic [NUM_MASTERS-1:0] w_rvalid;

    wr_state_t              r_wr_state;
    wr_state_t              w_wr_state_nxt;
    logic [GW-1:0]          r_wr_grant;
    logic [GW-1:0]          r_wr_ptr;
    logic                   r_aw_done;
    logic                   r_w_done;

    rd_state_t              r_rd_state;
    rd_state_t              w_rd_state_nxt;
    logic [GW-1:0]          r_rd_grant;
    logic [GW-1:0]          r_rd_ptr;

    logic                   w_s_awvalid;
    logic                   w_s_wvalid;
    logic                   w_s_bready;
    logic                   w_s_arvalid;
    logic                   w_s_rready;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;

    // Interface arrays only accept constant indices, so flatten them here.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        assign w_awvalid[gi]     = m_if[gi].AWVALID;
        assign w_wvalid[gi]      = m_if[gi].WVALID;
        assign w_bready[gi]      = m_if[gi].BREADY;
        assign w_arvalid[gi]     = m_if[gi].ARVALID;
        assign w_rready[gi]      = m_if[gi].RREADY;
        assign w_awaddr[gi]      = m_if[gi].AWADDR;
        assign w_araddr[gi]      = m_if[gi].ARADDR;
        assign w_wdata[gi]       = m_if[gi].WDATA;
        assign w_wstrb[gi]       = m_if[gi].WSTRB;

        assign m_if[gi].AWREADY  = w_awready[gi];
        assign m_if[gi].WREADY   = w_wready[gi];
        assign m_if[gi].BVALID   = w_bvalid[gi];
        assign m_if[gi].BRESP    = s_if.BRESP;
        assign m_if[gi].ARREADY  = w_arready[gi];
        assign m_if[gi].RVALID   = w_rvalid[gi];
        assign m_if[gi].RDATA    = s_if.RDATA;
        assign m_if[gi].RRESP    = s_if.RRESP;
    end

    function automatic logic [GW-1:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [GW-1:0]          ptr);
        logic [GW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        if (ARB_MODE == 1) begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (req[k]) win = GW'(k);
            end
        end else begin
            // Scan from the slot after the last owner so it drops to lowest priority.
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                idx = (int'(ptr) + k) % NUM_MASTERS;
                if (!found && req[idx]) begin
                    win   = GW'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_s_awvalid    = 1'b0;
        w_s_wvalid     = 1'b0;
        w_s_bready     = 1'b0;
        w_aw_hs        = 1'b0;
        w_w_hs         = 1'b0;
        w_b_hs         = 1'b0;
        w_awready      = '0;
        w_wready       = '0;
        w_bvalid       = '0;
        case (r_wr_state)
            W_IDLE: begin
                if (|w_awvalid) w_wr_state_nxt = W_ADDR;
            end
            W_ADDR: begin
                w_s_awvalid           = w_awvalid[r_wr_grant] & ~r_aw_done;
                w_s_wvalid            = w_wvalid[r_wr_grant] & ~r_w_done;
                w_awready[r_wr_grant] = s_if.AWREADY & ~r_aw_done;
                w_wready[r_wr_grant]  = s_if.WREADY & ~r_w_done;
                w_aw_hs               = w_s_awvalid & s_if.AWREADY;
                w_w_hs                = w_s_wvalid & s_if.WREADY;
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid[r_wr_grant]  = s_if.BVALID;
                w_s_bready            = w_bready[r_wr_grant];
                w_b_hs                = s_if.BVALID & w_bready[r_wr_grant];
                if (w_b_hs) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wr_grant <= '0;
            r_wr_ptr   <= GW'(NUM_MASTERS - 1);
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            case (r_wr_state)
                W_IDLE: begin
                    if (|w_awvalid) begin
                        r_wr_grant <= f_pick(w_awvalid, r_wr_ptr);
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                    end
                end
                W_ADDR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                W_RESP: begin
                    if (w_b_hs) r_wr_ptr <= r_wr_grant;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_s_arvalid    = 1'b0;
        w_s_rready     = 1'b0;
        w_ar_hs        = 1'b0;
        w_r_hs         = 1'b0;
        w_arready      = '0;
        w_rvalid       = '0;
        case (r_rd_state)
            R_IDLE: begin
                if (|w_arvalid) w_rd_state_nxt = R_ADDR;
            end
            R_ADDR: begin
                w_s_arvalid           = w_arvalid[r_rd_grant];
                w_arready[r_rd_grant] = s_if.ARREADY;
                w_ar_hs               = w_s_arvalid & s_if.ARREADY;
                if (w_ar_hs) w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid[r_rd_grant]  = s_if.RVALID;
                w_s_rready            = w_rready[r_rd_grant];
                w_r_hs                = s_if.RVALID & w_rready[r_rd_grant];
                if (w_r_hs) w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_rd_grant <= '0;
            r_rd_ptr   <= GW'(NUM_MASTERS - 1);
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (r_rd_state == R_IDLE && (|w_arvalid)) r_rd_grant <= f_pick(w_arvalid, r_rd_ptr);
            if (r_rd_state == R_DATA && w_r_hs)       r_rd_ptr   <= r_rd_grant;
        end
    end

    // Payload lines always follow the registered owner; only VALID/READY are state-gated.
    assign s_if.AWVALID = w_s_awvalid;
    assign s_if.AWADDR  = w_awaddr[r_wr_grant];
    assign s_if.WVALID  = w_s_wvalid;
    assign s_if.WDATA   = w_wdata[r_wr_grant];
    assign s_if.WSTRB   = w_wstrb[r_wr_grant];
    assign s_if.BREADY  = w_s_bready;
    assign s_if.ARVALID = w_s_arvalid;
    assign s_if.ARADDR  = w_araddr[r_rd_grant];
    assign s_if.RREADY  = w_s_rready;

    assign wr_grant = r_wr_grant;
    assign rd_grant = r_rd_grant;
    assign wr_busy  = (r_wr_state != W_IDLE);
    assign rd_busy  = (r_rd_state != R_IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter: master/slave models with a scoreboard,
// plus a second fixed-priority instance under permanent contention.
module tb_axi_lite_rr_arbiter;

    typedef struct packed {
        logic [1:0]  m;
        logic [31:0] v;
        logic [3:0]  s;
    } rec_t;

    logic        clk;
    logic        rst_n;
    int          total = 0;
    int          bad   = 0;
    int          w_count = 0;
    int          m_rep [4];

    rec_t aw_exp[$];
    rec_t w_exp[$];
    rec_t b_exp[$];
    rec_t ar_exp[$];
    rec_t r_exp[$];

    // master-side drive and observation
    logic [3:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr [4];
    logic [31:0] m_araddr [4];
    logic [31:0] m_wdata  [4];
    logic [3:0]  m_wstrb  [4];
    logic [3:0]  o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp [4];
    logic [31:0] o_rdata [4];

    // slave model state
    logic        sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
    logic [1:0]  sl_bresp;
    logic [31:0] sl_rdata;
    logic [31:0] sl_raddr;
    logic        sl_aw_got, sl_w_got;

    logic [1:0]  wr_grant, rd_grant, f_wr_grant, f_rd_grant;
    logic        wr_busy, rd_busy, f_wr_busy, f_rd_busy;

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_bus [4] ();
    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();
    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) f_bus [4] ();
    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fs_bus ();

    for (genvar gi = 0; gi < 4; gi++) begin : g_tbm
        assign m_bus[gi].AWVALID = m_awvalid[gi];
        assign m_bus[gi].AWADDR  = m_awaddr[gi];
        assign m_bus[gi].WVALID  = m_wvalid[gi];
        assign m_bus[gi].WDATA   = m_wdata[gi];
        assign m_bus[gi].WSTRB   = m_wstrb[gi];
        assign m_bus[gi].BREADY  = m_bready[gi];
        assign m_bus[gi].ARVALID = m_arvalid[gi];
        assign m_bus[gi].ARADDR  = m_araddr[gi];
        assign m_bus[gi].RREADY  = m_rready[gi];
        assign o_awready[gi]     = m_bus[gi].AWREADY;
        assign o_wready[gi]      = m_bus[gi].WREADY;
        assign o_bvalid[gi]      = m_bus[gi].BVALID;
        assign o_bresp[gi]       = m_bus[gi].BRESP;
        assign o_arready[gi]     = m_bus[gi].ARREADY;
        assign o_rvalid[gi]      = m_bus[gi].RVALID;
        assign o_rdata[gi]       = m_bus[gi].RDATA;

        assign f_bus[gi].AWVALID = 1'b1;
        assign f_bus[gi].AWADDR  = 32'(gi * 16);
        assign f_bus[gi].WVALID  = 1'b1;
        assign f_bus[gi].WDATA   = 32'(gi);
        assign f_bus[gi].WSTRB   = 4'hF;
        assign f_bus[gi].BREADY  = 1'b1;
        assign f_bus[gi].ARVALID = 1'b0;
        assign f_bus[gi].ARADDR  = 32'h0;
        assign f_bus[gi].RREADY  = 1'b1;
    end

    assign s_bus.AWREADY  = sl_awready;
    assign s_bus.WREADY   = sl_wready;
    assign s_bus.BVALID   = sl_bvalid;
    assign s_bus.BRESP    = sl_bresp;
    assign s_bus.ARREADY  = sl_arready;
    assign s_bus.RVALID   = sl_rvalid;
    assign s_bus.RDATA    = sl_rdata;
    assign s_bus.RRESP    = 2'b00;

    assign fs_bus.AWREADY = 1'b1;
    assign fs_bus.WREADY  = 1'b1;
    assign fs_bus.BVALID  = 1'b1;
    assign fs_bus.BRESP   = 2'b00;
    assign fs_bus.ARREADY = 1'b1;
    assign fs_bus.RVALID  = 1'b0;
    assign fs_bus.RDATA   = 32'h0;
    assign fs_bus.RRESP   = 2'b00;

    axi_lite_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(4), .ARB_MODE(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_if     (m_bus),
        .s_if     (s_bus),
        .wr_grant (wr_grant),
        .rd_grant (rd_grant),
        .wr_busy  (wr_busy),
        .rd_busy  (rd_busy)
    );

    axi_lite_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(4), .ARB_MODE(1)) dut_fixed (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_if     (f_bus),
        .s_if     (fs_bus),
        .wr_grant (f_wr_grant),
        .rd_grant (f_rd_grant),
        .wr_busy  (f_wr_busy),
        .rd_busy  (f_rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rec_t mk(input logic [1:0] m, input logic [31:0] v, input logic [3:0] s);
        rec_t r;
        r.m = m;
        r.v = v;
        r.s = s;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_write(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_awaddr[i]  = a;
        m_wdata[i]   = d;
        m_wstrb[i]   = s;
        m_awvalid[i] = 1'b1;
        m_wvalid[i]  = 1'b1;
        aw_exp.push_back(mk(2'(i), a, 4'h0));
        w_exp.push_back(mk(2'(i), d, s));
        b_exp.push_back(mk(2'(i), 32'h0, 4'h0));
    endtask

    task automatic issue_read(input int i, input logic [31:0] a);
        m_araddr[i]  = a;
        m_arvalid[i] = 1'b1;
        ar_exp.push_back(mk(2'(i), a, 4'h0));
        r_exp.push_back(mk(2'(i), a ^ 32'h5A5A_0000, 4'h0));
    endtask

    // One clock: sample handshakes mid-cycle, then update both models after the edge.
    task automatic cycle();
        logic [3:0] aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic       saw, sw, sb, sar, sr;
        rec_t       e;
        @(negedge clk);
        aw_hs = m_awvalid & o_awready;
        w_hs  = m_wvalid & o_wready;
        b_hs  = o_bvalid & m_bready;
        ar_hs = m_arvalid & o_arready;
        r_hs  = o_rvalid & m_rready;
        saw   = s_bus.AWVALID & sl_awready;
        sw    = s_bus.WVALID & sl_wready;
        sb    = sl_bvalid & s_bus.BREADY;
        sar   = s_bus.ARVALID & sl_arready;
        sr    = sl_rvalid & s_bus.RREADY;
        if (saw) begin
            if (aw_exp.size() == 0) chk("aw_unexpected", aw_exp.size(), 1);
            else begin
                e = aw_exp.pop_front();
                chk("aw_grant", wr_grant, e.m);
                chk("aw_addr", s_bus.AWADDR, e.v);
            end
        end
        if (sw) begin
            w_count++;
            if (w_exp.size() == 0) chk("w_unexpected", w_exp.size(), 1);
            else begin
                e = w_exp.pop_front();
                chk("w_data", s_bus.WDATA, e.v);
                chk("w_strb", s_bus.WSTRB, e.s);
            end
        end
        if (sar) begin
            sl_raddr = s_bus.ARADDR;
            if (ar_exp.size() == 0) chk("ar_unexpected", ar_exp.size(), 1);
            else begin
                e = ar_exp.pop_front();
                chk("ar_grant", rd_grant, e.m);
                chk("ar_addr", s_bus.ARADDR, e.v);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (b_hs[i]) begin
                if (b_exp.size() == 0) chk("b_unexpected", b_exp.size(), 1);
                else begin
                    e = b_exp.pop_front();
                    chk("b_master", i, e.m);
                    chk("b_resp", o_bresp[i], 2'b00);
                    chk("b_others", o_bvalid & ~(4'b0001 << i), 4'b0000);
                end
            end
            if (r_hs[i]) begin
                if (r_exp.size() == 0) chk("r_unexpected", r_exp.size(), 1);
                else begin
                    e = r_exp.pop_front();
                    chk("r_master", i, e.m);
                    chk("r_data", o_rdata[i], e.v);
                    chk("r_others", o_rvalid & ~(4'b0001 << i), 4'b0000);
                end
            end
        end
        @(posedge clk);
        #1;
        m_awvalid = m_awvalid & ~aw_hs;
        m_wvalid  = m_wvalid & ~w_hs;
        m_arvalid = m_arvalid & ~ar_hs;
        for (int i = 0; i < 4; i++) begin
            if (b_hs[i] && m_rep[i] > 0) begin
                m_rep[i]--;
                m_awaddr[i]  = m_awaddr[i] + 32'h1000;
                m_wdata[i]   = m_wdata[i] + 32'd1;
                m_awvalid[i] = 1'b1;
                m_wvalid[i]  = 1'b1;
            end
        end
        if (sb)  sl_bvalid = 1'b0;
        if (saw) sl_aw_got = 1'b1;
        if (sw)  sl_w_got  = 1'b1;
        if (sl_aw_got && sl_w_got && !sl_bvalid) begin
            sl_bvalid = 1'b1;
            sl_bresp  = 2'b00;
            sl_aw_got = 1'b0;
            sl_w_got  = 1'b0;
        end
        if (sr) sl_rvalid = 1'b0;
        if (sar) begin
            sl_rvalid = 1'b1;
            sl_rdata  = sl_raddr ^ 32'h5A5A_0000;
        end
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int  n;
        logic idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < max_cycles) begin
            cycle();
            n++;
            idle = (aw_exp.size() == 0) && (w_exp.size() == 0) && (b_exp.size() == 0) &&
                   (ar_exp.size() == 0) && (r_exp.size() == 0) && !wr_busy && !rd_busy &&
                   (m_awvalid == 4'h0) && (m_arvalid == 4'h0);
        end
        chk("idle_within_budget", idle, 1'b1);
    endtask

    initial begin
        int fcount;
        int wbefore;
        rst_n      = 1'b0;
        m_awvalid  = 4'hF;
        m_wvalid   = 4'hF;
        m_arvalid  = 4'hF;
        m_bready   = 4'hF;
        m_rready   = 4'hF;
        for (int i = 0; i < 4; i++) begin
            m_awaddr[i] = 32'h0;
            m_araddr[i] = 32'h0;
            m_wdata[i]  = 32'h0;
            m_wstrb[i]  = 4'h0;
            m_rep[i]    = 0;
        end
        sl_awready = 1'b1;
        sl_wready  = 1'b1;
        sl_arready = 1'b1;
        sl_bvalid  = 1'b0;
        sl_bresp   = 2'b00;
        sl_rvalid  = 1'b0;
        sl_rdata   = 32'h0;
        sl_raddr   = 32'h0;
        sl_aw_got  = 1'b0;
        sl_w_got   = 1'b0;

        // Reset held with every master requesting
        repeat (3) @(posedge clk);
        #2;
        chk("rst_s_valid_ready", {s_bus.AWVALID, s_bus.WVALID, s_bus.ARVALID, s_bus.BREADY, s_bus.RREADY}, 5'b0);
        chk("rst_m_ready", {o_awready, o_wready, o_arready}, 12'h000);
        chk("rst_m_valid", {o_bvalid, o_rvalid}, 8'h00);
        chk("rst_grants", {wr_grant, rd_grant}, 4'h0);
        chk("rst_busy", {wr_busy, rd_busy}, 2'b00);
        m_awvalid = 4'h0;
        m_wvalid  = 4'h0;
        m_arvalid = 4'h0;
        rst_n     = 1'b1;
        cycle();

        // Round-robin under continuous contention: 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) issue_write(i, 32'h1000_0000 + 32'(i * 256), 32'hA000_0000 + 32'(i), 4'hF);
        m_rep[0] = 1;
        m_rep[1] = 1;
        for (int i = 0; i < 2; i++) begin
            aw_exp.push_back(mk(2'(i), 32'h1000_1000 + 32'(i * 256), 4'h0));
            w_exp.push_back(mk(2'(i), 32'hA000_0001 + 32'(i), 4'hF));
            b_exp.push_back(mk(2'(i), 32'h0, 4'h0));
        end
        wait_idle(100);

        // Fixed-priority instance keeps picking master 0
        fcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (fs_bus.AWVALID && fcount < 3) begin
                chk("fixed_grant", f_wr_grant, 2'd0);
                chk("fixed_addr", fs_bus.AWADDR, 32'h0);
                fcount++;
            end
        end
        chk("fixed_grant_count", fcount, 3);
        @(posedge clk);
        #2;

        // Single write from master 2
        issue_write(2, 32'h100, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("no_comb_aw_path", s_bus.AWVALID, 1'b0);
        cycle();
        chk("single_awvalid", s_bus.AWVALID, 1'b1);
        chk("single_awaddr", s_bus.AWADDR, 32'h100);
        chk("single_grant", wr_grant, 2'd2);
        cycle();
        chk("single_bvalid_route", o_bvalid, 4'b0100);
        wait_idle(20);

        // W accepted three cycles ahead of AW
        sl_awready = 1'b0;
        wbefore = w_count;
        issue_write(1, 32'h200, 32'h1234_5678, 4'h3);
        cycle();
        cycle();
        chk("split_wvalid_dropped", s_bus.WVALID, 1'b0);
        chk("split_awvalid_held", s_bus.AWVALID, 1'b1);
        chk("split_no_bready", s_bus.BREADY, 1'b0);
        cycle();
        chk("split_wvalid_still_low", s_bus.WVALID, 1'b0);
        cycle();
        sl_awready = 1'b1;
        cycle();
        chk("split_resp_valids", {s_bus.AWVALID, s_bus.WVALID}, 2'b00);
        chk("split_resp_bready", s_bus.BREADY, 1'b1);
        chk("split_bvalid_route", o_bvalid, 4'b0010);
        wait_idle(20);
        chk("split_w_beats", w_count - wbefore, 1);

        // Concurrent write (M0) and read (M3)
        issue_write(0, 32'h10, 32'hCAFE_0000, 4'hF);
        issue_read(3, 32'h20);
        cycle();
        chk("conc_busy", {wr_busy, rd_busy}, 2'b11);
        chk("conc_grants", {wr_grant, rd_grant}, {2'd0, 2'd3});
        wait_idle(30);

        // Reset while a write response is pending
        m_bready[0] = 1'b0;
        issue_write(0, 32'h300, 32'h0BAD_F00D, 4'hF);
        cycle();
        cycle();
        cycle();
        chk("rresp_pending_bvalid", o_bvalid, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", wr_busy, 1'b0);
        chk("rst_mid_bvalid", o_bvalid, 4'b0000);
        chk("rst_mid_s_lines", {s_bus.BREADY, s_bus.AWVALID, s_bus.WVALID}, 3'b000);
        chk("rst_mid_grant", wr_grant, 2'd0);
        sl_bvalid   = 1'b0;
        sl_aw_got   = 1'b0;
        sl_w_got    = 1'b0;
        m_bready[0] = 1'b1;
        m_awvalid   = 4'h0;
        m_wvalid    = 4'h0;
        aw_exp.delete();
        w_exp.delete();
        b_exp.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        issue_write(1, 32'h400, 32'h5555_AAAA, 4'hC);
        cycle();
        chk("post_rst_grant", wr_grant, 2'd1);
        chk("post_rst_busy", wr_busy, 1'b1);
        wait_idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
